// File: rtl/adc_pkg.sv
// adc_pkg: state encoding, power-on default configuration and latency helper
// shared by the multi-channel ADC serial front end.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNV,
    GAP,
    SCK_LO,
    SCK_HI,
    DONE
  } adc_state_t;

  localparam logic [31:0] DEF_PERIOD_CFG  = 32'd41;
  localparam logic [7:0]  DEF_CNV_CFG     = 8'd5;
  localparam logic [7:0]  DEF_SCK_DIV_CFG = 8'd0;

  // Clocks from the tick-accepting edge to sample_valid_p rising.
  function automatic int unsigned conv_latency(input int unsigned cnv_cfg,
                                               input int unsigned sck_div_cfg,
                                               input int unsigned data_w);
    return cnv_cfg + 3 + 2 * data_w * (sck_div_cfg + 1);
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Purpose: sample-period counter; one-clock tick every period_cfg_p+1 clocks while enabled.
// Latency: tick is combinational from the counter register, same cycle it reaches the period.
// Backpressure: none; ticks are produced regardless of consumer state.
module adc_tick_gen
  import adc_pkg::*;
(
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic        enable_p,
  input  logic [31:0] period_cfg_p,
  output logic        tick_p
);

  logic [31:0] cnt;

  // Count 0..period, wrap; held at 0 while disabled. The >= compare keeps a
  // period shrunk below the current count from stalling for 2^32 clocks.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      cnt <= '0;
    end else if (!enable_p || (cnt >= period_cfg_p)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

  assign tick_p = enable_p && !reset_p && (cnt >= period_cfg_p);

endmodule

// File: rtl/adc_multi_interface.sv
// Purpose: shared CNV/SCK driver for NUM_CH serial ADCs, parallel SDO capture, valid/ready output.
// Latency: sample_valid_p rises C+3+2*DATA_W*(D+1) clocks after the tick-accepting edge.
// Backpressure: a held sample is never overwritten; new samples are dropped and counted.
// Optional build macro ADC_TEST_PATTERN_EN replaces captured data with a per-conversion counter.
module adc_multi_interface
  import adc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int OVR_W  = 16
) (
  input  logic                       clk210_p,
  input  logic                       reset_p,
  input  logic                       enable_p,
  input  logic [31:0]                period_cfg_p,
  input  logic [7:0]                 cnv_cfg_p,
  input  logic [7:0]                 sck_div_cfg_p,
  input  logic [NUM_CH-1:0]          sdo_p,
  output logic                       cnv_p,
  output logic                       sck_p,
  output logic [NUM_CH*DATA_W-1:0]   sample_data_p,
  output logic                       sample_valid_p,
  input  logic                       sample_ready_p,
  output logic                       busy_p,
  output logic                       tick_miss_p,
  output logic [OVR_W-1:0]           overrun_cnt_p
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  adc_state_t               state, state_d;
  logic [7:0]               cyc_cnt, cyc_cnt_d;
  logic [BIT_W-1:0]         bit_cnt, bit_cnt_d;
  logic [7:0]               cnv_sh, div_sh;
  logic                     latch_cfg, shift_en, done_now, tick;
  logic [NUM_CH*DATA_W-1:0] new_data;

  adc_tick_gen u_tick_gen (
    .clk210_p     (clk210_p),
    .reset_p      (reset_p),
    .enable_p     (enable_p),
    .period_cfg_p (period_cfg_p),
    .tick_p       (tick)
  );

  // State, timing counters, shadow config and registered CNV/SCK pins.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      cnv_sh  <= '0;
      div_sh  <= '0;
      cnv_p   <= 1'b0;
      sck_p   <= 1'b1;
    end else begin
      state   <= state_d;
      cyc_cnt <= cyc_cnt_d;
      bit_cnt <= bit_cnt_d;
      if (latch_cfg) begin
        cnv_sh <= cnv_cfg_p;
        div_sh <= sck_div_cfg_p;
      end
      cnv_p <= (state_d == CNV);
      sck_p <= (state_d != SCK_LO);
    end
  end

  // Next-state: CNV pulse, setup gap, DATA_W SCK periods, one-clock result hand-off.
  always_comb begin
    state_d   = state;
    cyc_cnt_d = cyc_cnt + 8'd1;
    bit_cnt_d = bit_cnt;
    latch_cfg = 1'b0;
    shift_en  = 1'b0;
    done_now  = 1'b0;
    case (state)
      IDLE: begin
        cyc_cnt_d = '0;
        if (tick) begin
          state_d   = CNV;
          latch_cfg = 1'b1;
        end
      end
      CNV: begin
        if (cyc_cnt == cnv_sh) begin
          state_d   = GAP;
          cyc_cnt_d = '0;
        end
      end
      GAP: begin
        state_d   = SCK_LO;
        cyc_cnt_d = '0;
      end
      SCK_LO: begin
        if (cyc_cnt == div_sh) begin
          state_d   = SCK_HI;
          cyc_cnt_d = '0;
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      SCK_HI: begin
        if (cyc_cnt == div_sh) begin
          cyc_cnt_d = '0;
          state_d   = (bit_cnt == BIT_W'(DATA_W)) ? DONE : SCK_LO;
        end
      end
      DONE: begin
        state_d   = IDLE;
        cyc_cnt_d = '0;
        bit_cnt_d = '0;
        done_now  = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        cyc_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

`ifdef ADC_TEST_PATTERN_EN
  logic [DATA_W-1:0] pat_cnt;

  // Pattern advances on every completed conversion, dropped ones included.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      pat_cnt <= '0;
    end else if (done_now) begin
      pat_cnt <= pat_cnt + 1'b1;
    end
  end

  // Channel k carries pattern + k.
  always_comb begin
    new_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      new_data[k*DATA_W +: DATA_W] = pat_cnt + DATA_W'(k);
    end
  end
`else
  logic [DATA_W-1:0] shreg [NUM_CH];

  // Capture each SDO lane at the SCK rising edge, MSB first into the LSB end.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      for (int k = 0; k < NUM_CH; k++) shreg[k] <= '0;
    end else if (shift_en) begin
      for (int k = 0; k < NUM_CH; k++) shreg[k] <= {shreg[k][DATA_W-2:0], sdo_p[k]};
    end
  end

  // Flatten the shift registers into the output word layout.
  always_comb begin
    new_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      new_data[k*DATA_W +: DATA_W] = shreg[k];
    end
  end
`endif

  // Output holding register: load when empty or draining, otherwise drop and count.
  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      sample_data_p  <= '0;
      sample_valid_p <= 1'b0;
      overrun_cnt_p  <= '0;
    end else if (done_now) begin
      if (!sample_valid_p || sample_ready_p) begin
        sample_data_p  <= new_data;
        sample_valid_p <= 1'b1;
      end else if (overrun_cnt_p != '1) begin
        overrun_cnt_p <= overrun_cnt_p + 1'b1;
      end
    end else if (sample_valid_p && sample_ready_p) begin
      sample_valid_p <= 1'b0;
    end
  end

  assign busy_p      = (state != IDLE);
  assign tick_miss_p = tick && busy_p;

endmodule

// File: tb/tb_adc_multi_interface.sv
// Directed bench for adc_multi_interface: ADC serial models on each SDO lane,
// scoreboard queue of expected words filled at conversion start, drained on transfer.
module tb_adc_multi_interface;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 16;
  localparam int OVR_W  = 16;

  logic                     clk210_p = 1'b0;
  logic                     reset_p = 1'b1;
  logic                     enable_p = 1'b0;
  logic [31:0]              period_cfg_p = 32'd41;
  logic [7:0]               cnv_cfg_p = 8'd5;
  logic [7:0]               sck_div_cfg_p = 8'd0;
  logic [NUM_CH-1:0]        sdo_p;
  logic                     cnv_p, sck_p, sample_valid_p, busy_p, tick_miss_p;
  logic                     sample_ready_p = 1'b1;
  logic [NUM_CH*DATA_W-1:0] sample_data_p;
  logic [OVR_W-1:0]         overrun_cnt_p;

  always #2 clk210_p = ~clk210_p;

  adc_multi_interface #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OVR_W(OVR_W)) dut (
    .clk210_p       (clk210_p),
    .reset_p        (reset_p),
    .enable_p       (enable_p),
    .period_cfg_p   (period_cfg_p),
    .cnv_cfg_p      (cnv_cfg_p),
    .sck_div_cfg_p  (sck_div_cfg_p),
    .sdo_p          (sdo_p),
    .cnv_p          (cnv_p),
    .sck_p          (sck_p),
    .sample_data_p  (sample_data_p),
    .sample_valid_p (sample_valid_p),
    .sample_ready_p (sample_ready_p),
    .busy_p         (busy_p),
    .tick_miss_p    (tick_miss_p),
    .overrun_cnt_p  (overrun_cnt_p)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk210_p) cyc <= cyc + 1;

  // ADC models: MSB presented after CNV rises, next bit after each SCK rise.
  logic [15:0] w0 = 16'hA5C3;
  logic [15:0] w1 = 16'h1234;
  int idx = 0;
  always @(posedge cnv_p) idx = DATA_W - 1;
  always @(posedge sck_p) if (idx > 0) idx = idx - 1;
  assign sdo_p = {w1[idx], w0[idx]};

`ifdef ADC_TEST_PATTERN_EN
  logic [15:0] pat_m = 16'd0;
`endif

  function automatic logic [31:0] next_exp();
`ifdef ADC_TEST_PATTERN_EN
    next_exp = {pat_m + 16'd1, pat_m};
    pat_m = pat_m + 16'd1;
`else
    next_exp = {w1, w0};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard drain on transfer, event counters.
  logic [31:0] sb[$];
  int xfers = 0, miss_cnt = 0, sck_falls = 0, sck_rises = 0;
  logic sck_prev = 1'b1;
  always @(negedge clk210_p) begin
    if (tick_miss_p === 1'b1) miss_cnt++;
    if (sck_prev === 1'b1 && sck_p === 1'b0) sck_falls++;
    if (sck_prev === 1'b0 && sck_p === 1'b1) sck_rises++;
    sck_prev = sck_p;
    if (sample_valid_p === 1'b1 && sample_ready_p === 1'b1 && reset_p === 1'b0) begin
      xfers++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed data %0h with no expected entry", sample_data_p);
      end
      if (sb.size() != 0) chk("xfer_data", sample_data_p, sb.pop_front());
    end
  end

  function automatic logic sig_of(input int which);
    case (which)
      0:       return cnv_p;
      1:       return busy_p;
      2:       return sck_p;
      default: return sample_valid_p;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input string tag, output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk210_p);
      n++;
    end while (sig_of(which) !== val && n < 600);
    if (sig_of(which) !== val) chk(tag, sig_of(which), val);
    t = cyc;
  endtask

  // One conversion: start it, optionally keep ticking, optionally change SCK div mid-flight.
  task automatic one_conv(input string tag, input bit keep, input bit hold_en, input bit cfg_mid,
                          output int lat, output int cw);
    int t0, t1;
    logic [31:0] e;
    enable_p = 1'b1;
    wait_sig(0, 1'b1, {tag, "_cnv_timeout"}, t0);
    if (!hold_en) enable_p = 1'b0;
    e = next_exp();
    if (keep) sb.push_back(e);
    cw = 1;
    while (cnv_p === 1'b1 && cw < 300) begin
      @(negedge clk210_p);
      if (cnv_p === 1'b1) cw++;
    end
    if (cfg_mid) begin
      wait_sig(2, 1'b0, {tag, "_sck_timeout"}, t1);
      sck_div_cfg_p = 8'd3;
    end
    wait_sig(1, 1'b0, {tag, "_busy_timeout"}, t1);
    lat = t1 - t0;
    chk({tag, "_valid"}, sample_valid_p, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cw, f0, m0, x0, r0, t0, n;

    // Reset
    repeat (3) @(posedge clk210_p);
    #1;
    chk("rst_cnv", cnv_p, 1'b0);
    chk("rst_sck", sck_p, 1'b1);
    chk("rst_valid", sample_valid_p, 1'b0);
    chk("rst_data", sample_data_p, 32'h0);
    chk("rst_busy", busy_p, 1'b0);
    chk("rst_miss", tick_miss_p, 1'b0);
    chk("rst_ovr", overrun_cnt_p, 16'h0);
    reset_p = 1'b0;

    // Basic conversion, C=5 D=0
    f0 = sck_falls; m0 = miss_cnt; x0 = xfers;
    one_conv("basic", 1'b1, 1'b0, 1'b0, lat, cw);
    chk("basic_cnv_width", cw, 6);
    chk("basic_latency", lat, 40);
    chk("basic_sck_falls", sck_falls - f0, 16);
    @(negedge clk210_p);
    chk("basic_xfers", xfers - x0, 1);
    chk("basic_miss", miss_cnt - m0, 0);

    // Backpressure: second sample dropped, first held
    @(posedge clk210_p); #1;
    sample_ready_p = 1'b0;
    w0 = 16'h0F0F; w1 = 16'hBEEF;
    x0 = xfers;
    one_conv("bp1", 1'b1, 1'b0, 1'b0, lat, cw);
    chk("bp1_latency", lat, 40);
    w0 = 16'h5555; w1 = 16'hAAAA;
    one_conv("bp2", 1'b0, 1'b0, 1'b0, lat, cw);
    chk("bp_ovr", overrun_cnt_p, 16'd1);
    chk("bp_hold_data", sample_data_p, sb[0]);
    chk("bp_no_xfer", xfers - x0, 0);
    @(posedge clk210_p); #1;
    sample_ready_p = 1'b1;
    @(negedge clk210_p);
    @(negedge clk210_p);
    chk("bp_valid_clear", sample_valid_p, 1'b0);
    chk("bp_xfers", xfers - x0, 1);

    // Tick miss: period 10, three accepted conversions, 3 misses during each of first two
    @(posedge clk210_p); #1;
    period_cfg_p = 32'd10;
    w0 = 16'h3C3C; w1 = 16'h8001;
    m0 = miss_cnt; x0 = xfers;
    one_conv("tm1", 1'b1, 1'b1, 1'b0, lat, cw);
    chk("tm1_latency", lat, 40);
    one_conv("tm2", 1'b1, 1'b1, 1'b0, lat, cw);
    chk("tm2_latency", lat, 40);
    one_conv("tm3", 1'b1, 1'b0, 1'b0, lat, cw);
    chk("tm3_latency", lat, 40);
    @(negedge clk210_p);
    chk("tm_miss_count", miss_cnt - m0, 6);
    chk("tm_xfers", xfers - x0, 3);
    chk("tm_ovr_unchanged", overrun_cnt_p, 16'd1);

    // Config change mid-conversion takes effect on the next one
    @(posedge clk210_p); #1;
    period_cfg_p = 32'd200;
    w0 = 16'h6B2D; w1 = 16'hF00D;
    one_conv("cfgA", 1'b1, 1'b0, 1'b1, lat, cw);
    chk("cfgA_latency", lat, 40);
    f0 = sck_falls;
    one_conv("cfgB", 1'b1, 1'b0, 1'b0, lat, cw);
    chk("cfgB_latency", lat, 136);
    chk("cfgB_sck_falls", sck_falls - f0, 16);
    chk("cfgB_cnv_width", cw, 6);
    @(posedge clk210_p); #1;
    sck_div_cfg_p = 8'd0;
    period_cfg_p = 32'd41;

    // Reset mid-SCK after 7 bits
    w0 = 16'hC0DE; w1 = 16'h7E57;
    enable_p = 1'b1;
    wait_sig(0, 1'b1, "rst2_cnv_timeout", t0);
    enable_p = 1'b0;
    r0 = sck_rises;
    n = 0;
    while (sck_rises - r0 < 7 && n < 500) begin
      @(negedge clk210_p);
      n++;
    end
    chk("rst2_bits_seen", sck_rises - r0, 7);
    reset_p = 1'b1;
    @(posedge clk210_p); #1;
    chk("rst2_sck", sck_p, 1'b1);
    chk("rst2_cnv", cnv_p, 1'b0);
    chk("rst2_valid", sample_valid_p, 1'b0);
    chk("rst2_busy", busy_p, 1'b0);
    chk("rst2_ovr", overrun_cnt_p, 16'h0);
    reset_p = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
    pat_m = 16'd0;
`endif
    one_conv("after_rst", 1'b1, 1'b0, 1'b0, lat, cw);
    chk("after_rst_latency", lat, 40);

    @(negedge clk210_p);
    @(negedge clk210_p);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_multi_interface.md
Name: adc_multi_interface

Overview:
Parametrised successor to the single-channel ADC serial front end. It drives shared CNV/SCK lines to NUM_CH simultaneously-sampling serial ADCs and shifts in one SDO lane per channel. Sample rate, CNV pulse width and SCK rate are runtime-configurable. Results go out on a valid/ready handshake to the downstream FIFO/RAM path, with loss accounting.

Parameters:
NUM_CH, 2, number of ADCs / SDO lanes sharing CNV and SCK
DATA_W, 16, bits per conversion, MSB first
OVR_W, 16, width of saturating overrun counter

Ports:
clk210_p  in  1  system clock, 210 MHz
reset_p  in  1  synchronous, active-high reset
enable_p  in  1  sampling enable; gates the period counter
period_cfg_p  in  32  sample period minus 1, in clocks
cnv_cfg_p  in  8  CNV high time minus 1, in clocks
sck_div_cfg_p  in  8  SCK half-period minus 1, in clocks
sdo_p  in  NUM_CH  serial data from each ADC
cnv_p  out  1  convert strobe to all ADCs
sck_p  out  1  serial clock to all ADCs, idles high
sample_data_p  out  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
sample_valid_p  out  1  sample available
sample_ready_p  in  1  downstream accepts
busy_p  out  1  high whenever state != IDLE
tick_miss_p  out  1  one-cycle pulse: period tick arrived while busy
overrun_cnt_p  out  OVR_W  samples dropped due to backpressure, saturating

Behaviour:
- Reset values: cnv_p=0, sck_p=1, sample_valid_p=0, sample_data_p=0, busy_p=0, tick_miss_p=0, overrun_cnt_p=0; state=IDLE; all counters=0.
- Reset asserted mid-conversion aborts it. All outputs take reset values on the next edge. The partial sample is discarded.
- Period counter: held at 0 while enable_p=0. Otherwise counts 0..period_cfg_p and emits tick (1 cycle) on reaching period_cfg_p, then wraps to 0. Tick spacing = period_cfg_p+1 clocks.
- States: IDLE, CNV, GAP, SCK_LO, SCK_HI, DONE.
- IDLE: on tick, latch C=cnv_cfg_p and D=sck_div_cfg_p into shadow registers; cnv_p<=1; go to CNV. Config changes take effect only at this latch point.
- CNV: cnv_p high for C+1 clocks, then cnv_p<=0; go to GAP.
- GAP: one clock, satisfying the CNV-fall-to-SCK setup time; go to SCK_LO.
- SCK_LO: sck_p low for D+1 clocks; go to SCK_HI.
- SCK_HI: on the entry edge (sck rise), shift sdo_p[k] into shift register k at the LSB. Hold sck_p high for D+1 clocks. After DATA_W rises go to DONE; else return to SCK_LO.
- DONE (1 clock): if sample_valid_p=0, or it is being accepted this cycle, load sample_data_p and set sample_valid_p=1. Otherwise drop the new sample, keep the old one, and increment overrun_cnt_p (saturate at all-ones). Return to IDLE.
- Handshake: a transfer occurs when valid&&ready. sample_valid_p clears next cycle unless DONE reloads it in that same cycle. sample_data_p is stable while valid is high.
- Latency: tick at cycle T gives sample_valid_p high at T+C+3+2*DATA_W*(D+1).
- Tick while busy: ignored; tick_miss_p pulses in the same cycle. Required spacing: period_cfg_p+1 > C+3+2*DATA_W*(D+1).
- enable_p falling mid-conversion: the current conversion completes; no further ticks.

Optional Feature:
ADC_TEST_PATTERN_EN
- Defined: shifting and SCK timing are unchanged, but DONE loads channel k with {pattern counter + k} (DATA_W bits). The pattern counter increments per completed conversion, including dropped ones, and resets to 0. sdo_p is ignored.
- Undefined: no counter logic; data comes from sdo_p.

Decomposition:
- Package adc_pkg: state encoding enum (IDLE..DONE), default config constants (period 41, CNV 5, SCK div 0), and the latency helper function.
- Sub-module adc_tick_gen: period counter, enable gating and tick output. The main FSM, shift registers and handshake stay in adc_multi_interface.

Test Plan:
- Reset: hold reset_p 3 cycles -> cnv_p=0, sck_p=1, valid=0, overrun_cnt_p=0, busy_p=0.
- Basic conversion: NUM_CH=2, C=5, D=0, period 41, ready=1, ADC models drive ch0=0xA5C3, ch1=0x1234 -> cnv_p high 6 clocks; 16 SCK cycles of 2 clocks; valid at T+40; sample_data_p=0x1234A5C3; no tick_miss_p.
- Backpressure: ready=0 over two conversions -> first sample held unchanged, overrun_cnt_p=1. Then ready=1 -> one transfer of the first sample.
- Tick miss: period_cfg_p=10, C=5, D=0 -> tick_miss_p pulses on ticks arriving while busy; every accepted conversion still yields exactly one valid sample.
- Config mid-conversion: change D 0->3 during SCK_LO -> current sample still uses 2-clock SCK. Next sample (period 200) uses 8-clock SCK; latency 5+3+128=136.
- Reset mid-SCK after 7 bits -> next cycle sck_p=1, cnv_p=0, valid=0. The next conversion after reset returns the full correct word.
